// File: rtl/rs485_frame_tx.sv
// rtl/rs485_frame_tx.sv - ping-pong buffered RS-485 word burst transmitter with driver guard timing
module rs485_frame_tx #(
    parameter int WORD_W  = 18,
    parameter int NWORDS  = 97,
    parameter int BIT_DIV = 1,
    parameter int PARITY  = 0,
    parameter int DLY_RX  = 10,
    parameter int DLY_TX  = 5,
    parameter int DLY_EN  = 15,
    parameter int DLY_REL = 5
) (
    input  logic              clk5MHz,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] data_in,
    output logic              rs485_tx,
    output logic              dir_RX,
    output logic              dir_TX,
    output logic              accept,
    output logic              busy,
    output logic              overflow
);
    localparam int FB = (PARITY != 0) ? 11 : 10;
    localparam int AW = $clog2(2 * NWORDS);

    typedef enum logic [2:0] {IDLE, PRE_RX, PRE_TX, PRE_EN, SEND, POST, REL} state_t;

    logic [WORD_W-1:0] mem [2*NWORDS];
    logic [1:0]        full;
    logic              wbank;
    logic              tbank;
    logic [7:0]        wptr;
    logic [7:0]        widx;
    logic [7:0]        ld_widx;
    logic [1:0]        byi;
    logic [1:0]        ld_byi;
    logic [3:0]        bidx;
    logic [15:0]       cnt;
    logic [15:0]       bcnt;
    logic [9:0]        sh;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [10:0]       ld_frame;
    logic              last_byte;
    logic              rel_done;
    state_t            state;

    // Byte 0 = word[15:8], byte 1 = word[7:0], byte 2 = upper bits left-justified.
    function automatic logic [7:0] byte_sel(input logic [WORD_W-1:0] w, input logic [1:0] i);
        logic [23:0] w24;
        w24 = 24'(w);
        case (i)
            2'd0:    return w24[15:8];
            2'd1:    return w24[7:0];
            default: return w24[23:16] << (24 - WORD_W);
        endcase
    endfunction

    // Line bits in transmit order: start, data MSB first, optional parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[7-i];
        if (PARITY == 1)      f[9] = ^b;
        else if (PARITY == 2) f[9] = ~^b;
        return f;
    endfunction

    assign waddr     = AW'(int'(wptr) + (wbank ? NWORDS : 0));
    assign last_byte = (byi == 2'd2) && (widx == 8'(NWORDS - 1));
    assign rel_done  = (state == REL) && (cnt >= 16'(DLY_REL - 1));

    // Index of the byte to load next: word 0 byte 0 before the burst, else the successor.
    always_comb begin
        ld_widx = 8'd0;
        ld_byi  = 2'd0;
        if (state == SEND) begin
            ld_byi  = (byi == 2'd2) ? 2'd0 : byi + 2'd1;
            ld_widx = (byi == 2'd2) ? widx + 8'd1 : widx;
        end
    end

    assign raddr    = AW'(int'(ld_widx) + (tbank ? NWORDS : 0));
    assign ld_frame = frame_of(byte_sel(mem[raddr], ld_byi));

    // Write side: fill the current bank, flag it full, drop writes into a full bank.
    always_ff @(posedge clk5MHz) begin
        if (rst) begin
            full     <= 2'b00;
            wptr     <= 8'd0;
            wbank    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (rel_done) full[tbank] <= 1'b0;
            if (wr_en) begin
                if (full[wbank]) begin
                    overflow <= 1'b1;
                end else begin
                    mem[waddr] <= data_in;
                    if (wptr == 8'(NWORDS - 1)) begin
                        full[wbank] <= 1'b1;
                        wptr        <= 8'd0;
                        wbank       <= ~wbank;
                    end else begin
                        wptr <= wptr + 8'd1;
                    end
                end
            end
        end
    end

    // Transaction FSM: guard sequence, serial burst of the selected bank, release.
    always_ff @(posedge clk5MHz) begin
        if (rst) begin
            state    <= IDLE;
            rs485_tx <= 1'b1;
            dir_RX   <= 1'b0;
            dir_TX   <= 1'b0;
            accept   <= 1'b0;
            busy     <= 1'b0;
            tbank    <= 1'b0;
            cnt      <= 16'd0;
            bcnt     <= 16'd0;
            bidx     <= 4'd0;
            byi      <= 2'd0;
            widx     <= 8'd0;
            sh       <= '1;
        end else begin
            case (state)
                IDLE: begin
                    rs485_tx <= 1'b1;
                    if (|full) begin
                        // With both banks full the write bank pointer names the older one.
                        tbank  <= (&full) ? wbank : full[1];
                        accept <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= 16'd0;
                        state  <= PRE_RX;
                    end
                end
                PRE_RX: begin
                    if (cnt == 16'(DLY_RX - 1)) begin
                        dir_RX <= 1'b1;
                        cnt    <= 16'd0;
                        state  <= PRE_TX;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PRE_TX: begin
                    if (cnt == 16'(DLY_TX - 1)) begin
                        dir_TX <= 1'b1;
                        cnt    <= 16'd0;
                        state  <= PRE_EN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PRE_EN: begin
                    if (cnt == 16'(DLY_EN - 1)) begin
                        widx     <= 8'd0;
                        byi      <= 2'd0;
                        bidx     <= 4'd0;
                        bcnt     <= 16'd0;
                        rs485_tx <= ld_frame[0];
                        sh       <= ld_frame[10:1];
                        state    <= SEND;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SEND: begin
                    if (bcnt == 16'(BIT_DIV - 1)) begin
                        bcnt <= 16'd0;
                        if (bidx == 4'(FB - 1)) begin
                            if (last_byte) begin
                                dir_TX   <= 1'b0;
                                rs485_tx <= 1'b1;
                                cnt      <= 16'd0;
                                state    <= POST;
                            end else begin
                                widx     <= ld_widx;
                                byi      <= ld_byi;
                                bidx     <= 4'd0;
                                rs485_tx <= ld_frame[0];
                                sh       <= ld_frame[10:1];
                            end
                        end else begin
                            bidx     <= bidx + 4'd1;
                            rs485_tx <= sh[0];
                            sh       <= {1'b1, sh[9:1]};
                        end
                    end else begin
                        bcnt <= bcnt + 16'd1;
                    end
                end
                POST: begin
                    // The release delay is counted from the dir_TX drop, so POST's cycle counts.
                    rs485_tx <= 1'b1;
                    cnt      <= cnt + 16'd1;
                    state    <= REL;
                end
                REL: begin
                    if (rel_done) begin
                        dir_RX <= 1'b0;
                        accept <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs485_frame_tx.sv
// tb/tb_rs485_frame_tx.sv - self-checking bench for rs485_frame_tx
module tb_rs485_frame_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        wr0 = 1'b0, wr1 = 1'b0;
    logic [17:0] d0 = '0, d1 = '0;
    logic        tx0, drx0, dtx0, acc0, bsy0, ovf0;
    logic        tx1, drx1, dtx1, acc1, bsy1, ovf1;

    rs485_frame_tx u0 (
        .clk5MHz(clk), .rst(rst), .wr_en(wr0), .data_in(d0),
        .rs485_tx(tx0), .dir_RX(drx0), .dir_TX(dtx0),
        .accept(acc0), .busy(bsy0), .overflow(ovf0)
    );

    rs485_frame_tx #(.NWORDS(2), .BIT_DIV(4), .PARITY(1)) u1 (
        .clk5MHz(clk), .rst(rst), .wr_en(wr1), .data_in(d1),
        .rs485_tx(tx1), .dir_RX(drx1), .dir_TX(dtx1),
        .accept(acc1), .busy(bsy1), .overflow(ovf1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr = 0;
    int ferr [2] = '{0, 0};
    int aborts [2] = '{0, 0};
    int rx0_q[$], rx1_q[$], par1_q[$], exp0[$], exp1[$];
    int acc0_q[$], rxr0_q[$], txr0_q[$], st0_q[$], txf0_q[$], rxf0_q[$];
    int acc1_q[$], st1_q[$], txf1_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic mon_tx(input int w);
        return (w != 0) ? tx1 : tx0;
    endfunction

    function automatic logic mon_dtx(input int w);
        return (w != 0) ? dtx1 : dtx0;
    endfunction

    task automatic rx_frame(input int w);
        int div, fb, b;
        logic [10:0] bits;
        bit bad;
        div  = (w != 0) ? 4 : 1;
        fb   = (w != 0) ? 11 : 10;
        bits = '1;
        bad  = 0;
        b    = 0;
        for (int k = 0; k < fb; k++) begin
            for (int j = 0; j < div; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                if (mon_dtx(w) !== 1'b1) begin
                    aborts[w]++;
                    return;
                end
                if (j == 0) bits[k] = mon_tx(w);
                else if (mon_tx(w) !== bits[k]) bad = 1;
            end
        end
        for (int i = 0; i < 8; i++) b = b * 2 + int'(bits[1+i]);
        if (bits[0] !== 1'b0 || bits[fb-1] !== 1'b1) bad = 1;
        if (w != 0) begin
            if (bits[9] !== ^(8'(b))) bad = 1;
            par1_q.push_back(int'(bits[9]));
            rx1_q.push_back(b);
        end else begin
            rx0_q.push_back(b);
        end
        if (bad) ferr[w]++;
    endtask

    always @(negedge clk) if (rst !== 1'b1 && dtx0 === 1'b1 && tx0 === 1'b0) rx_frame(0);
    always @(negedge clk) if (rst !== 1'b1 && dtx1 === 1'b1 && tx1 === 1'b0) rx_frame(1);

    logic p_acc0 = 0, p_drx0 = 0, p_dtx0 = 0, p_acc1 = 0, p_dtx1 = 0;
    bit arm0 = 0, arm1 = 0;
    always @(negedge clk) begin
        if (acc0 === 1'b1 && p_acc0 !== 1'b1) acc0_q.push_back(cyc);
        if (drx0 === 1'b1 && p_drx0 !== 1'b1) rxr0_q.push_back(cyc);
        if (drx0 !== 1'b1 && p_drx0 === 1'b1) rxf0_q.push_back(cyc);
        if (dtx0 === 1'b1 && p_dtx0 !== 1'b1) begin txr0_q.push_back(cyc); arm0 = 1; end
        if (dtx0 !== 1'b1 && p_dtx0 === 1'b1) txf0_q.push_back(cyc);
        if (arm0 && tx0 === 1'b0) begin st0_q.push_back(cyc); arm0 = 0; end
        if (acc1 === 1'b1 && p_acc1 !== 1'b1) acc1_q.push_back(cyc);
        if (dtx1 === 1'b1 && p_dtx1 !== 1'b1) arm1 = 1;
        if (dtx1 !== 1'b1 && p_dtx1 === 1'b1) txf1_q.push_back(cyc);
        if (arm1 && tx1 === 1'b0) begin st1_q.push_back(cyc); arm1 = 0; end
        p_acc0 = acc0; p_drx0 = drx0; p_dtx0 = dtx0; p_acc1 = acc1; p_dtx1 = dtx1;
    end

    function automatic void exp_word(input int w, input int v);
        int b2;
        b2 = (v >> 10) & (255 << 6) & 255;
        if (w != 0) begin
            exp1.push_back((v >> 8) & 255); exp1.push_back(v & 255); exp1.push_back(b2);
        end else begin
            exp0.push_back((v >> 8) & 255); exp0.push_back(v & 255); exp0.push_back(b2);
        end
    endfunction

    task automatic wr(input int w, input int v);
        @(negedge clk);
        if (w != 0) begin wr1 = 1'b1; d1 = 18'(v); end
        else begin wr0 = 1'b1; d0 = 18'(v); end
        last_wr = cyc + 1;
    endtask

    task automatic wr_idle();
        @(negedge clk);
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    task automatic wait_n(input int w, input int n, input int budget);
        int t;
        t = 0;
        while (((w == 0) ? rxf0_q.size() : txf1_q.size()) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("burst_done", ((w == 0) ? rxf0_q.size() : txf1_q.size()), n);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_guard0(input int k, input int base);
        chk("accept_rise", acc0_q[k], base);
        chk("dir_RX_rise", rxr0_q[k], base + 10);
        chk("dir_TX_rise", txr0_q[k], base + 15);
        chk("first_start", st0_q[k], base + 30);
        chk("dir_TX_fall", txf0_q[k], base + 30 + 2910);
        chk("dir_RX_fall", rxf0_q[k], base + 30 + 2910 + 5);
    endtask

    task automatic chk_bytes0();
        chk("rx0_count", rx0_q.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < rx0_q.size(); i++) chk("rx0_byte", rx0_q[i], exp0[i]);
        chk("rx0_framing", ferr[0], 0);
    endtask

    task automatic clear0();
        rx0_q.delete(); exp0.delete(); acc0_q.delete(); rxr0_q.delete();
        txr0_q.delete(); st0_q.delete(); txf0_q.delete(); rxf0_q.delete();
    endtask

    initial begin
        int base, v, t;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx0, 1'b1);
        chk("rst_dir_RX", drx0, 1'b0);
        chk("rst_dir_TX", dtx0, 1'b0);
        chk("rst_accept", acc0, 1'b0);
        chk("rst_busy", bsy0, 1'b0);
        chk("rst_overflow", ovf0, 1'b0);
        rst = 1'b0;

        wr(1, 'h3A5C3); exp_word(1, 'h3A5C3);
        wr(1, 'h00007); exp_word(1, 'h00007);
        wr_idle();
        base = last_wr + 1;
        wait_n(1, 1, 1000);
        chk("u1_accept_rise", acc1_q[0], base);
        chk("u1_first_start", st1_q[0], base + 30);
        chk("u1_burst_len", txf1_q[0], base + 30 + 2 * 3 * 11 * 4);
        chk("u1_rx_count", rx1_q.size(), 6);
        for (int i = 0; i < 6 && i < rx1_q.size(); i++) chk("u1_byte", rx1_q[i], exp1[i]);
        chk("u1_parity_07", par1_q[4], 1);
        chk("u1_framing", ferr[1], 0);
        chk("u1_overflow", ovf1, 1'b0);

        for (int i = 0; i < 97; i++) begin wr(0, i); exp_word(0, i); end
        wr_idle();
        base = last_wr + 1;
        wait_n(0, 1, 4000);
        chk_guard0(0, base);
        chk_bytes0();
        chk("idle_busy", bsy0, 1'b0);

        clear0();
        for (int i = 0; i < 194; i++) begin
            v = int'($urandom & 32'h3FFFF);
            wr(0, v);
            exp_word(0, v);
            if (i == 96) base = last_wr + 1;
        end
        wr_idle();
        chk("no_overflow_194", ovf0, 1'b0);
        wr(0, int'($urandom & 32'h3FFFF));
        wr_idle();
        chk("overflow_set", ovf0, 1'b1);
        wait_n(0, 2, 8000);
        chk_guard0(0, base);
        chk_guard0(1, base + 2946);
        chk_bytes0();
        chk("overflow_sticky", ovf0, 1'b1);

        clear0();
        for (int i = 0; i < 97; i++) begin
            v = int'($urandom & 32'h3FFFF);
            wr(0, v);
            exp_word(0, v);
        end
        wr_idle();
        t = 0;
        while (st0_q.size() == 0 && t < 500) begin @(negedge clk); t++; end
        chk("mid_start_seen", st0_q.size(), 1);
        while (cyc < st0_q[0] + 164) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx0, 1'b1);
        chk("mid_rst_dir_TX", dtx0, 1'b0);
        chk("mid_rst_dir_RX", drx0, 1'b0);
        chk("mid_rst_accept", acc0, 1'b0);
        chk("mid_rst_busy", bsy0, 1'b0);
        chk("mid_rst_overflow", ovf0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rx_count", rx0_q.size(), 16);
        for (int i = 0; i < 16 && i < rx0_q.size(); i++) chk("mid_byte", rx0_q[i], exp0[i]);
        chk("mid_abort", aborts[0], 1);

        clear0();
        for (int i = 0; i < 97; i++) begin
            v = int'($urandom & 32'h3FFFF);
            wr(0, v);
            exp_word(0, v);
        end
        wr_idle();
        base = last_wr + 1;
        wait_n(0, 1, 4000);
        chk_guard0(0, base);
        chk_bytes0();
        chk("final_overflow", ovf0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rs485_frame_tx.md
Name: rs485_frame_tx

Overview:
Parametrised successor to the single-buffer RS-485 word transmitter. It collects NWORDS words written by a synchronous strobe into a ping-pong buffer of two banks. Each full bank is sent as a burst of UART-style bytes, with programmable driver-direction guard timing and a programmable baud divider. It sits between the data-gathering logic and the RS-485 transceiver pins (dir_RX/dir_TX).

Parameters:
WORD_W, 18, data word width; legal range 17..24; each word is sent as 3 bytes
NWORDS, 97, words per burst (bank depth); legal range 2..255
BIT_DIV, 1, clk5MHz cycles per line bit; legal range 1..65535
PARITY, 0, 0 = none, 1 = even, 2 = odd; when non-zero, a parity bit is inserted before the stop bit
DLY_RX, 10, cycles from accept rising to dir_RX asserting
DLY_TX, 5, cycles from dir_RX to dir_TX
DLY_EN, 15, cycles from dir_TX to the first start bit
DLY_REL, 5, cycles from dir_TX dropping to dir_RX dropping

Ports:
clk5MHz  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe; data_in is captured on every clock edge where wr_en=1
data_in  in  WORD_W  word to store
rs485_tx  out  1  serial line; idles high (mark)
dir_RX  out  1  receiver-disable / bus-claim control
dir_TX  out  1  driver enable
accept  out  1  high for the whole transaction, from bank-full until release completes
busy  out  1  high whenever the FSM is not in IDLE
overflow  out  1  sticky flag; set when a write is dropped

Behaviour:
- Reset values: rs485_tx=1; dir_RX, dir_TX, accept, busy, overflow = 0. Both banks are marked empty, write pointer = 0, write bank = 0, FSM = IDLE. Memory contents are not reset.
- Write side:
  - A wr_en cycle stores data_in at [wbank][wptr] and increments wptr.
  - When wptr reaches NWORDS-1 on a write, the bank is marked full, wptr returns to 0 and wbank toggles.
  - If the target bank is still full (not yet transmitted), the write is dropped and overflow is set. overflow stays set until rst.
- FSM states: IDLE, PRE_RX, PRE_TX, PRE_EN, SEND, POST, REL.
  - IDLE: if either bank is full, select the oldest full bank (tbank), set accept=1 on the next edge, go to PRE_RX.
  - PRE_RX: count DLY_RX cycles, then dir_RX=1, go to PRE_TX.
  - PRE_TX: count DLY_TX cycles, then dir_TX=1, go to PRE_EN.
  - PRE_EN: count DLY_EN cycles, then go to SEND.
  - SEND: send words 0..NWORDS-1 of tbank, 3 bytes per word.
  - POST: entered after the final stop bit; dir_TX=0 on entry, line forced to 1.
  - REL: count DLY_REL cycles, then dir_RX=0, accept=0, mark tbank empty, go to IDLE.
  - A bank that fills during a transaction is started from IDLE one cycle after REL exits, with the full guard sequence repeated.
- Byte order per word: byte0 = word[15:8], byte1 = word[7:0], byte2 = {word[WORD_W-1:16], zero pad} left-justified (bit WORD_W-1 in byte position 7).
- Byte frame, one bit each, in order: start 0, data MSB first, optional parity, stop 1. That is 10 bits, or 11 bits with parity.
- Bit timing: every bit holds for exactly BIT_DIV cycles. Bytes are back-to-back with no idle gap. The burst lasts NWORDS×3×framebits×BIT_DIV cycles.
- Parity is computed over the 8 data bits: even gives XOR of the bits, odd gives its inverse.
- Simultaneous events:
  - A write completing a bank in the same cycle the FSM is in IDLE is seen on the next cycle.
  - A write to the bank currently being read is impossible by construction, because that bank is full and such writes are dropped.
- rst mid-burst: all outputs return to reset values on the next edge and both banks are emptied; the interrupted frame is abandoned.

Test Plan:
1. Defaults; write 97 words, data_in = index. Required: accept rises 1 cycle after the 97th write; dir_RX rises 10 cycles later; dir_TX 5 cycles after that; first start bit 15 cycles after dir_TX. Word 1 is sent as bytes 0x00, 0x01, 0x00. Burst = 2910 bit cycles.
2. Write word 0x3A5C3 as the first word with NWORDS=2. Required bytes: 0xA5, 0xC3, 0xC0 (bits 17:16 = 11).
3. PARITY=1, BIT_DIV=4, data 0x00007. Required: byte1 = 0x07 with parity bit 1; every bit lasts 4 cycles; frame is 11 bits.
4. Write 194 words back-to-back. Required: both bank bursts are sent; the second burst is preceded by a fresh 10/5/15 guard sequence; overflow stays 0.
5. With both banks full during a burst, write 1 more word. Required: overflow=1 and stays set; the transmitted data is unchanged.
6. Assert rst midway through byte1 of word 5. Required: next edge gives rs485_tx=1, dir_TX=0, dir_RX=0, accept=0, busy=0; a new 97-word fill transmits correctly.
